// File: rtl/down_counter_if.sv
// Control and status bundle for the loadable down-counter.
// The master drives the load/count controls and the counter (slave) returns count and flags.
interface down_counter_if #(
    parameter int unsigned WIDTH = 3
) ();
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             done;
    logic             busy;

    modport master (
        output en, load, load_val, auto_reload,
        input  out, tc, done, busy
    );

    modport slave (
        input  en, load, load_val, auto_reload,
        output out, tc, done, busy
    );
endinterface

// File: rtl/down_counter.sv
// Loadable synchronous down-counter with one-shot / periodic reload and terminal-count flag.
// Sequenced by an IDLE/RUN/DONE controller; every output comes straight from a flop.
module down_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    down_counter_if.slave bus
);
    localparam int unsigned W = WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   out_q,   out_d;
    logic [W-1:0]   rl_q,    rl_d;
    logic           tc_q,    tc_d;
    logic           done_q,  done_d;
    logic           busy_q,  busy_d;

    // Next-state and next-output decode: load > (RUN & en) > hold.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rl_d    = rl_q;
        tc_d    = 1'b0;
        done_d  = done_q;

        if (bus.load) begin
            out_d = bus.load_val;
            rl_d  = bus.load_val;
            if ((bus.load_val == W'(0)) && !bus.auto_reload) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                done_d  = 1'b0;
            end
        end else if ((state_q == ST_RUN) && bus.en) begin
            if (out_q != W'(0)) begin
                out_d = out_q - W'(1);
                tc_d  = (out_q == W'(1));
                if ((out_q == W'(1)) && !bus.auto_reload) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else if (bus.auto_reload) begin
                out_d = rl_q;
                tc_d  = (rl_q == W'(0));
            end else begin
                // Periodic mode dropped while parked at zero: finish without a new tc.
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '1;
            rl_q    <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rl_q    <= rl_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.tc   = tc_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: each step queues its expected outputs, which are
// popped and compared just after the clock edge that should produce them.
module tb_down_counter;
    localparam int unsigned W = 3;

    typedef struct {
        int       step;
        logic [W-1:0] out;
        logic     tc;
        logic     done;
        logic     busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   step_no;
    exp_t sb_q[$];

    down_counter_if #(.WIDTH(W)) bus ();

    down_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected result, clock, then compare.
    task automatic cyc(input logic rst, input logic en, input logic ld,
                       input logic [W-1:0] lv, input logic ar,
                       input logic [W-1:0] e_out, input logic e_tc,
                       input logic e_done, input logic e_busy);
        exp_t e;
        exp_t got;
        rst_n           = rst;
        bus.en          = en;
        bus.load        = ld;
        bus.load_val    = lv;
        bus.auto_reload = ar;
        step_no++;
        e.step = step_no;
        e.out  = e_out;
        e.tc   = e_tc;
        e.done = e_done;
        e.busy = e_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check($sformatf("out@%0d", got.step),  int'(bus.out),  int'(got.out));
        check($sformatf("tc@%0d", got.step),   int'(bus.tc),   int'(got.tc));
        check($sformatf("done@%0d", got.step), int'(bus.done), int'(got.done));
        check($sformatf("busy@%0d", got.step), int'(bus.busy), int'(got.busy));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;
        rst_n           = 1'b0;
        bus.en          = 1'b1;
        bus.load        = 1'b0;
        bus.load_val    = '0;
        bus.auto_reload = 1'b0;
        @(negedge clk);

        // Reset with en high, then en ignored in IDLE
        cyc(0, 1, 0, 0, 0, 7, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 7, 0, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0, 7, 0, 0, 0);

        // One-shot from 5
        cyc(1, 1, 1, 5, 0, 5, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 4, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 3, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 2, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);

        // Auto-reload period of 3 from DONE, then drop mode at zero
        cyc(1, 1, 1, 2, 1, 2, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 1, 2, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 1, 2, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);

        // Enable gating
        cyc(1, 1, 1, 4, 0, 4, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 3, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 3, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 3, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 2, 0, 0, 1);

        // Load beats en; zero loads in both modes
        cyc(1, 0, 1, 3, 0, 3, 0, 0, 1);
        cyc(1, 1, 1, 6, 0, 6, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 1, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 1);

        // Full-scale one-shot start, then reset mid-count
        cyc(1, 1, 1, 7, 0, 7, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 6, 0, 0, 1);
        cyc(1, 1, 1, 5, 0, 5, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 4, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 3, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 7, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 7, 0, 0, 0);

        // Reset glitch between edges during a count has no effect
        cyc(1, 1, 1, 5, 0, 5, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 4, 0, 0, 1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc(1, 1, 0, 0, 0, 3, 0, 0, 1);

        // One-shot from 1 reaches terminal count on the first decrement
        cyc(1, 1, 1, 1, 0, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 1, 1, 0);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
